// File: rtl/xswitch_pkg.sv
// Shared constants and types for the crossbar output arbiters.
// Holds the port count, the port index type, the per-output FSM states and the rr advance helper.
package xswitch_pkg;

    localparam int NPORTS = 4;
    localparam int IDX_W  = 2;

    typedef logic [IDX_W-1:0] port_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic port_idx_t next_rr(input port_idx_t p, input int nports);
        return (int'(p) == nports - 1) ? '0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/xswitch_out_arb.sv
// One crossbar output: round-robin pick among requesting inputs, ownership until eop or stall timeout.
// Holds the per-output FSM, the rr pointer and the stall counter.
//
// state   | meaning
// ST_IDLE | no owner; pick the first candidate at or after rr
// ST_BUSY | sel owns this output until an eop beat or a stall timeout
module xswitch_out_arb
    import xswitch_pkg::*;
#(
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 64,
    parameter int OUT_IDX = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      req_valid,
    input  logic [NPORTS-1:0][1:0] req_dest,
    input  logic [NPORTS-1:0]      req_eop,
    input  logic                   out_ready,
    input  logic [NPORTS-1:0]      gnt,
    output logic [NPORTS-1:0]      gnt_own,
    output port_idx_t              sel,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT - 1);

    arb_state_e        state, next_state;
    port_idx_t         rr, pick;
    logic [CW-1:0]     stall_cnt;
    logic [NPORTS-1:0] cand;
    logic              found, beat, stall, release_eop, release_to;
    int                idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        found       = 1'b0;
        pick        = '0;
        idx         = 0;
        cand        = '0;
        for (int i = 0; i < NPORTS; i++)
            cand[i] = req_valid[i] && (req_dest[i] == port_idx_t'(OUT_IDX)) && !gnt[i];
        for (int k = 0; k < NPORTS; k++) begin
            idx = (int'(rr) + k) % NPORTS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = port_idx_t'(idx);
            end
        end
        beat        = (state == ST_BUSY) && req_valid[sel] && out_ready;
        stall       = (state == ST_BUSY) && !req_valid[sel];
        release_eop = beat && req_eop[sel];
        release_to  = stall && (stall_cnt == STALL_LAST);
        case (state)
            ST_IDLE: if (found) next_state = ST_BUSY;
            ST_BUSY: if (release_eop || release_to) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ST_BUSY);
        gnt_own = '0;
        if (busy) gnt_own[sel] = 1'b1;
    end

    // sel doubles as the owner index and keeps its value while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel         <= '0;
            rr          <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= release_to;
            if (state == ST_IDLE) begin
                stall_cnt <= '0;
                if (found) sel <= pick;
            end else if (release_eop || release_to) begin
                rr        <= next_rr(sel, NPORTS);
                stall_cnt <= '0;
            end else if (beat) begin
                stall_cnt <= '0;
            end else if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xswitch_arbiter.sv
// Crossbar switch arbiter: one independent arbiter per output, grants merged per input.
// Because each input names a single destination, the per-output grant vectors never overlap.
module xswitch_arbiter
    import xswitch_pkg::*;
#(
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS-1:0]      req_valid,
    input  logic [NPORTS-1:0][1:0] req_dest,
    input  logic [NPORTS-1:0]      req_eop,
    input  logic [NPORTS-1:0]      out_ready,
    output logic [NPORTS-1:0]      gnt,
    output logic [NPORTS-1:0][1:0] out_sel,
    output logic [NPORTS-1:0]      out_busy,
    output logic [NPORTS-1:0]      timeout_err
);

    logic [NPORTS-1:0] gnt_own [NPORTS];

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        xswitch_out_arb #(
            .NPORTS  (NPORTS),
            .TIMEOUT (TIMEOUT),
            .OUT_IDX (o)
        ) u_out_arb (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid),
            .req_dest    (req_dest),
            .req_eop     (req_eop),
            .out_ready   (out_ready[o]),
            .gnt         (gnt),
            .gnt_own     (gnt_own[o]),
            .sel         (out_sel[o]),
            .busy        (out_busy[o]),
            .timeout_err (timeout_err[o])
        );
    end

    always_comb begin
        gnt = '0;
        for (int o = 0; o < NPORTS; o++) gnt = gnt | gnt_own[o];
    end

endmodule

// File: tb/tb_xswitch_arbiter.sv
// Directed bench for xswitch_arbiter: single packet, round-robin order, parallel grants,
// stall timeout, long backpressure and mid-packet reset, against hand-computed values.
module tb_xswitch_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0][1:0]  req_dest;
    logic [3:0]       req_eop;
    logic [3:0]       out_ready;
    logic [3:0]       gnt;
    logic [3:0][1:0]  out_sel;
    logic [3:0]       out_busy;
    logic [3:0]       timeout_err;

    int n_vec  = 0;
    int n_miss = 0;
    logic [3:0] terr_seen;

    xswitch_arbiter #(.NPORTS(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_eop     (req_eop),
        .out_ready   (out_ready),
        .gnt         (gnt),
        .out_sel     (out_sel),
        .out_busy    (out_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_order [9] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_dest  = '0;
        req_eop   = '0;
        out_ready = 4'hF;
        step();
        step();
        chk("rst_gnt",  gnt,         0);
        chk("rst_busy", out_busy,    0);
        chk("rst_sel",  out_sel,     0);
        chk("rst_terr", timeout_err, 0);
        reset = 1'b1;

        // single-beat packet: input 2 -> output 1
        req_valid   = 4'b0100;
        req_dest[2] = 2'd1;
        req_eop     = 4'b0100;
        step();
        chk("one_gnt",  gnt,        4'b0100);
        chk("one_busy", out_busy,   4'b0010);
        chk("one_sel",  out_sel[1], 2);
        step();
        req_valid = '0;
        chk("one_rel_gnt",  gnt,        0);
        chk("one_rel_busy", out_busy,   0);
        chk("one_sel_hold", out_sel[1], 2);

        // four inputs contend for output 3 with one-beat packets
        req_valid = 4'b1111;
        req_dest  = {2'd3, 2'd3, 2'd3, 2'd3};
        req_eop   = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            step();
            chk($sformatf("rr_gnt_%0d", c), gnt, rr_order[c]);
        end
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("rr_end_gnt", gnt, 0);

        // two outputs pick in the same cycle
        req_valid   = 4'b1010;
        req_dest[1] = 2'd0;
        req_dest[3] = 2'd2;
        req_eop     = 4'b1010;
        step();
        chk("par_gnt",  gnt,        4'b1010);
        chk("par_busy", out_busy,   4'b0101);
        chk("par_sel0", out_sel[0], 1);
        chk("par_sel2", out_sel[2], 3);
        step();
        req_valid = '0;
        chk("par_rel", gnt, 0);

        // stall timeout: input 0 owns output 1 then goes silent; input 2 waits
        req_valid   = 4'b0001;
        req_dest[0] = 2'd1;
        req_dest[2] = 2'd1;
        req_eop     = 4'b0100;
        step();
        chk("to_gnt", gnt, 4'b0001);
        req_valid = 4'b0100;
        terr_seen = '0;
        for (int c = 0; c < 63; c++) begin
            step();
            terr_seen |= timeout_err;
        end
        chk("to_busy_63", out_busy,  4'b0010);
        chk("to_terr_63", terr_seen, 0);
        step();
        chk("to_terr",     timeout_err, 4'b0010);
        chk("to_busy_clr", out_busy,    0);
        chk("to_gnt_clr",  gnt,         0);
        step();
        chk("to_terr_once", timeout_err, 0);
        chk("to_next_gnt",  gnt,         4'b0100);
        chk("to_next_sel",  out_sel[1],  2);
        step();
        req_valid = '0;
        chk("to_next_rel", gnt, 0);

        // 200 cycles of backpressure inside a 4-beat packet
        req_valid   = 4'b0010;
        req_dest[1] = 2'd2;
        req_eop     = '0;
        out_ready   = 4'b1011;
        step();
        chk("bp_gnt", gnt, 4'b0010);
        terr_seen = '0;
        for (int c = 0; c < 200; c++) begin
            step();
            terr_seen |= timeout_err;
        end
        chk("bp_held", gnt,       4'b0010);
        chk("bp_terr", terr_seen, 0);
        out_ready = 4'hF;
        step();
        step();
        step();
        chk("bp_mid", gnt, 4'b0010);
        req_eop = 4'b0010;
        step();
        req_valid = '0;
        chk("bp_done",      gnt,         0);
        chk("bp_done_terr", timeout_err, 0);

        // reset in the middle of a 4-beat packet on output 0 (rr[0] was left at 2)
        req_valid   = 4'b1000;
        req_dest[3] = 2'd0;
        req_eop     = '0;
        step();
        chk("mr_gnt", gnt, 4'b1000);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("mr_async_gnt",  gnt,      0);
        chk("mr_async_busy", out_busy, 0);
        req_valid   = 4'b1010;
        req_dest[1] = 2'd0;
        step();
        chk("mr_hold_gnt", gnt,         0);
        chk("mr_terr",     timeout_err, 0);
        reset = 1'b1;
        step();
        chk("mr_rr0_gnt", gnt,        4'b0010);
        chk("mr_rr0_sel", out_sel[0], 1);
        req_valid = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
